// File: rtl/mem_ctrl.sv
// mem_ctrl: single-outstanding request/response controller for the 4x8-bit
// latch-based memory array. Sequences address/data setup, a registered store
// pulse and hold (writes) or a read sample, then returns a response.
//
// Optional feature macro: MEM_CTRL_VERIFY_EN (write readback verify).
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_write, req_addr, req_wdata  request payload
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata, rsp_err              response payload
//   mem_in, mem_store, mem_addy     drive to array in/store/addy
//   mem_rdata                       array mem output
module mem_ctrl #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ADDR_W       = 2,
  parameter int unsigned STORE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_store,
  output logic [ADDR_W-1:0] mem_addy,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned     CNT_W      = 4;
  localparam logic [CNT_W-1:0] STORE_LAST = CNT_W'(STORE_CYCLES - 1);
  // The store pulse is registered from the STORE state, so it trails the
  // state by one clock; HOLD spans that drain clock plus one clean hold clock.
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(1);

  if (STORE_CYCLES < 1 || STORE_CYCLES > 15) begin : g_bad_store_cycles
    $error("mem_ctrl: STORE_CYCLES must be in 1..15");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STORE,
    ST_HOLD,
`ifdef MEM_CTRL_VERIFY_EN
    ST_VERIFY,
`endif
    ST_SAMPLE,
    ST_RESP
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_write;
  logic               w_accept;
  logic               w_mem_store_d;
  logic               w_req_ready_d;
  logic               w_rsp_valid_d;
  logic               w_rsp_load;
  logic [DATA_W-1:0]  w_rsp_rdata_d;

  assign w_accept = req_valid && req_ready;

  // State register and store/hold clock counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
      end else if (r_state == ST_STORE || r_state == ST_HOLD) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_SETUP;
      ST_SETUP:  w_state_nxt = r_write ? ST_STORE : ST_SAMPLE;
      ST_STORE:  if (r_cnt == STORE_LAST) w_state_nxt = ST_HOLD;
`ifdef MEM_CTRL_VERIFY_EN
      ST_HOLD:   if (r_cnt == HOLD_LAST) w_state_nxt = ST_VERIFY;
      ST_VERIFY: w_state_nxt = ST_RESP;
`else
      ST_HOLD:   if (r_cnt == HOLD_LAST) w_state_nxt = ST_RESP;
`endif
      ST_SAMPLE: w_state_nxt = ST_RESP;
      ST_RESP:   if (rsp_ready) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode; every result feeds a flop below
  always_comb begin
    w_mem_store_d = (r_state == ST_STORE);
    // Ready stays low on the clock the FSM returns to IDLE after a response
    w_req_ready_d = (r_state == ST_IDLE) && (w_state_nxt == ST_IDLE);
    w_rsp_valid_d = (w_state_nxt == ST_RESP);
    w_rsp_load    = (r_state != ST_RESP) && (w_state_nxt == ST_RESP);
    w_rsp_rdata_d = '0;
    case (r_state)
      ST_SAMPLE: w_rsp_rdata_d = mem_rdata;
`ifdef MEM_CTRL_VERIFY_EN
      ST_VERIFY: w_rsp_rdata_d = mem_rdata;
`endif
      default:   w_rsp_rdata_d = '0;
    endcase
  end

  // Registered outputs and latched request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      mem_store <= 1'b0;
      mem_in    <= '0;
      mem_addy  <= '0;
      r_write   <= 1'b0;
    end else begin
      req_ready <= w_req_ready_d;
      rsp_valid <= w_rsp_valid_d;
      mem_store <= w_mem_store_d;
      if (w_accept) begin
        r_write  <= req_write;
        mem_in   <= req_wdata;
        mem_addy <= req_addr;
      end
      if (w_rsp_load) begin
        rsp_rdata <= w_rsp_rdata_d;
      end
    end
  end

`ifdef MEM_CTRL_VERIFY_EN
  // Verify flags a readback that differs from the data still on mem_in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err <= 1'b0;
    end else if (w_rsp_load) begin
      rsp_err <= (r_state == ST_VERIFY) && (mem_rdata != mem_in);
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a behavioural array model.
// Instance a uses STORE_CYCLES=1, instance b uses STORE_CYCLES=4; sel picks
// which instance the shared stimulus and observation signals talk to.
module tb_mem_ctrl;

`ifdef MEM_CTRL_VERIFY_EN
  localparam int WR_EXTRA = 4;
  localparam bit VERIFY   = 1'b1;
`else
  localparam int WR_EXTRA = 3;
  localparam bit VERIFY   = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic       req_valid, req_write, rsp_ready;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       force_en;
  logic [7:0] force_val;
  int         cur_sc;
  int         n_tests = 0;
  int         n_fail  = 0;

  logic       a_req_ready, a_rsp_valid, a_rsp_err, a_mem_store;
  logic [7:0] a_rsp_rdata, a_mem_in, a_mem_rdata;
  logic [1:0] a_mem_addy;
  logic       b_req_ready, b_rsp_valid, b_rsp_err, b_mem_store;
  logic [7:0] b_rsp_rdata, b_mem_in, b_mem_rdata;
  logic [1:0] b_mem_addy;
  logic       a_req_valid, b_req_valid;

  logic       req_ready, rsp_valid, rsp_err, mem_store;
  logic [7:0] rsp_rdata, mem_in;
  logic [1:0] mem_addy;

  logic [7:0] arr_a [4];
  logic [7:0] arr_b [4];

  always #5 clk = ~clk;

  assign a_req_valid = req_valid & ~sel;
  assign b_req_valid = req_valid & sel;
  assign req_ready   = sel ? b_req_ready : a_req_ready;
  assign rsp_valid   = sel ? b_rsp_valid : a_rsp_valid;
  assign rsp_err     = sel ? b_rsp_err   : a_rsp_err;
  assign mem_store   = sel ? b_mem_store : a_mem_store;
  assign rsp_rdata   = sel ? b_rsp_rdata : a_rsp_rdata;
  assign mem_in      = sel ? b_mem_in    : a_mem_in;
  assign mem_addy    = sel ? b_mem_addy  : a_mem_addy;

  always @(posedge clk) if (a_mem_store) arr_a[a_mem_addy] <= a_mem_in;
  always @(posedge clk) if (b_mem_store) arr_b[b_mem_addy] <= b_mem_in;
  assign a_mem_rdata = force_en ? force_val : arr_a[a_mem_addy];
  assign b_mem_rdata = force_en ? force_val : arr_b[b_mem_addy];

  mem_ctrl #(.DATA_W(8), .ADDR_W(2), .STORE_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err),
    .mem_in(a_mem_in), .mem_store(a_mem_store), .mem_addy(a_mem_addy),
    .mem_rdata(a_mem_rdata)
  );

  mem_ctrl #(.DATA_W(8), .ADDR_W(2), .STORE_CYCLES(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err),
    .mem_in(b_mem_in), .mem_store(b_mem_store), .mem_addy(b_mem_addy),
    .mem_rdata(b_mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] wr_rd(input logic [7:0] d);
    return VERIFY ? d : 8'h00;
  endfunction

  // One write; checks store pulse placement/width, bus stability and latency
  task automatic do_write(input logic [1:0] a, input logic [7:0] d,
                          input logic [7:0] exp_rd, input logic exp_err);
    int   st_first, st_cnt, rsp_at;
    logic bus_ok;
    @(negedge clk);
    chk("wr_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0; req_addr = 2'(a + 2'd1); req_wdata = ~d;
    chk("wr_ready_busy", req_ready, 0);
    st_first = -1; st_cnt = 0; rsp_at = -1; bus_ok = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (mem_store) begin
        if (st_first < 0) st_first = k;
        st_cnt++;
      end
      if (mem_addy !== a || mem_in !== d) bus_ok = 1'b0;
      if (rsp_valid) begin
        rsp_at = k;
        break;
      end
    end
    chk("wr_store_rise", st_first, 2);
    chk("wr_store_width", st_cnt, cur_sc);
    chk("wr_bus_stable", bus_ok, 1);
    chk("wr_rsp_latency", rsp_at, cur_sc + WR_EXTRA);
    chk("wr_rsp_rdata", rsp_rdata, exp_rd);
    chk("wr_rsp_err", rsp_err, exp_err);
    @(negedge clk);
    chk("wr_rsp_one_clk", rsp_valid, 0);
    chk("wr_ready_gap", req_ready, 0);
    @(negedge clk);
    chk("wr_ready_back", req_ready, 1);
  endtask

  // One read; optional response stall with an ignored request pulse inside it
  task automatic do_read(input logic [1:0] a, input logic [7:0] exp, input int stall);
    int   rsp_at;
    logic store_seen;
    @(negedge clk);
    chk("rd_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = 8'h00;
    if (stall > 0) rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; req_addr = ~a;
    chk("rd_ready_busy", req_ready, 0);
    rsp_at = -1; store_seen = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (mem_store) store_seen = 1'b1;
      if (rsp_valid) begin
        rsp_at = k;
        break;
      end
    end
    chk("rd_rsp_latency", rsp_at, 2);
    chk("rd_rsp_rdata", rsp_rdata, exp);
    chk("rd_rsp_err", rsp_err, 0);
    chk("rd_no_store", store_seen, 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (s == 1) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = 8'hEE;
      end
      if (s == 3) req_valid = 1'b0;
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_rdata", rsp_rdata, exp);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_no_store", mem_store, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rd_rsp_done", rsp_valid, 0);
    chk("rd_ready_gap", req_ready, 0);
    @(negedge clk);
    chk("rd_ready_back", req_ready, 1);
    chk("rd_no_extra_rsp", rsp_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stray;
    rst_n = 1'b1; sel = 1'b0; cur_sc = 1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 2'd0; req_wdata = 8'h00;
    rsp_ready = 1'b1; force_en = 1'b0; force_val = 8'h00;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_mem_store", mem_store, 0);
    chk("rst_mem_in", mem_in, 0);
    chk("rst_mem_addy", mem_addy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write then read back
    do_write(2'd2, 8'hA5, wr_rd(8'hA5), 1'b0);
    do_read(2'd2, 8'hA5, 0);

    // All four addresses, read back out of order
    do_write(2'd0, 8'h11, wr_rd(8'h11), 1'b0);
    do_write(2'd1, 8'h22, wr_rd(8'h22), 1'b0);
    do_write(2'd2, 8'h33, wr_rd(8'h33), 1'b0);
    do_write(2'd3, 8'h44, wr_rd(8'h44), 1'b0);
    do_read(2'd3, 8'h44, 0);
    do_read(2'd0, 8'h11, 0);
    do_read(2'd2, 8'h33, 0);
    do_read(2'd1, 8'h22, 0);

    // Response back-pressure; the write pulse inside the stall must be dropped
    do_write(2'd0, 8'h5A, wr_rd(8'h5A), 1'b0);
    do_read(2'd0, 8'h5A, 5);
    do_read(2'd0, 8'h5A, 0);

`ifdef MEM_CTRL_VERIFY_EN
    // Forced bad readback, then a clean verify
    force_en = 1'b1; force_val = 8'hA4;
    do_write(2'd3, 8'hA5, 8'hA4, 1'b1);
    force_en = 1'b0;
    do_write(2'd3, 8'h3C, 8'h3C, 1'b0);
    do_read(2'd3, 8'h3C, 0);
`endif

    // Reset while the store pulse is high
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd3; req_wdata = 8'h77;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_store", mem_store, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_store", mem_store, 0);
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    chk("rst_mid_rsp_rdata", rsp_rdata, 0);
    chk("rst_mid_rsp_err", rsp_err, 0);
    chk("rst_mid_mem_in", mem_in, 0);
    chk("rst_mid_mem_addy", mem_addy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid || mem_store) stray = 1'b1;
    end
    chk("rst_no_stray", stray, 0);
    chk("rst_ready_after", req_ready, 1);
    do_read(2'd2, 8'h33, 0);

    // Four-clock store pulse instance
    sel = 1'b1; cur_sc = 4;
    do_write(2'd1, 8'hFF, wr_rd(8'hFF), 1'b0);
    do_read(2'd1, 8'hFF, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
